// File: rtl/bus_master_mux_pipe.sv
// Bus master multiplexer with registered slave-side output stage.
// Picks the lowest-index granted master (active-low grants), registers its
// address/control/write data toward the slaves, holds that register while the
// addressed slave inserts wait states, and keeps sticky grant-protocol flags.
//
// Handshake: a transfer is presented when s_as_=0; the slave accepts it on a
// cycle with s_rdy_=0. While s_as_=0 and s_rdy_=1 the output register
// (address, strobe, rw, data, owner, owner_vld) is frozen; on every other
// cycle it loads the current selection.
module bus_master_mux_pipe #(
  parameter int NUM_MASTERS = 4,
  parameter int OWNER_W     = 2,
  parameter int ADDR_W      = 30,
  parameter int DATA_W      = 32
) (
  input  logic                          clk,
  input  logic                          reset_,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS-1:0]        m_as_,
  input  logic [NUM_MASTERS-1:0]        m_rw,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wr_data,
  input  logic [NUM_MASTERS-1:0]        m_grnt_,
  input  logic                          s_rdy_,
  input  logic                          err_clr,
  output logic [ADDR_W-1:0]             s_addr,
  output logic                          s_as_,
  output logic                          s_rw,
  output logic [DATA_W-1:0]             s_wr_data,
  output logic [OWNER_W-1:0]            s_owner,
  output logic                          s_owner_vld,
  output logic                          grnt_conflict,
  output logic                          handover_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  // Combinational selection (next-load values)
  logic [ADDR_W-1:0]      sel_addr;
  logic                   sel_as_;
  logic                   sel_rw;
  logic [DATA_W-1:0]      sel_wr_data;
  logic [OWNER_W-1:0]     sel_owner;
  logic                   sel_vld;

  logic [NUM_MASTERS-1:0] grant;
  logic                   multi_grant;
  logic                   stall;
  logic                   handover_set;

  // Fixed-priority select: scan high to low so the lowest granted index wins.
  always_comb begin
    sel_addr    = '0;
    sel_as_     = 1'b1;
    sel_rw      = 1'b1;
    sel_wr_data = '0;
    sel_owner   = '0;
    sel_vld     = 1'b0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (!m_grnt_[i]) begin
        sel_addr    = m_addr[i*ADDR_W +: ADDR_W];
        sel_as_     = m_as_[i];
        sel_rw      = m_rw[i];
        sel_wr_data = m_wr_data[i*DATA_W +: DATA_W];
        sel_owner   = OWNER_W'(i);
        sel_vld     = 1'b1;
      end
    end
  end

  // Protocol checks: two or more grants set when clearing the lowest set bit
  // still leaves a bit set; a handover is any owner change during a stall.
  always_comb begin
    grant        = ~m_grnt_;
    multi_grant  = |(grant & (grant - NUM_MASTERS'(1)));
    stall        = (state_q != ST_IDLE) && s_rdy_;
    handover_set = stall && (!sel_vld || (sel_owner != s_owner));
  end

  // Transfer state register.
  always_ff @(posedge clk) begin
    if (!reset_) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state: track whether a strobe is presented and whether it is stalled.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = sel_as_ ? ST_IDLE : ST_XFER;
      ST_XFER,
      ST_WAIT: begin
        if (s_rdy_) state_d = ST_WAIT;
        else        state_d = sel_as_ ? ST_IDLE : ST_XFER;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output register: load every cycle except while a transfer is stalled.
  always_ff @(posedge clk) begin
    if (!reset_) begin
      s_addr      <= '0;
      s_as_       <= 1'b1;
      s_rw        <= 1'b1;
      s_wr_data   <= '0;
      s_owner     <= '0;
      s_owner_vld <= 1'b0;
    end else if (!stall) begin
      s_addr      <= sel_addr;
      s_as_       <= sel_as_;
      s_rw        <= sel_rw;
      s_wr_data   <= sel_wr_data;
      s_owner     <= sel_owner;
      s_owner_vld <= sel_vld;
    end
  end

  // Sticky error flags: a set condition beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!reset_) begin
      grnt_conflict <= 1'b0;
      handover_err  <= 1'b0;
    end else begin
      grnt_conflict <= multi_grant  | (grnt_conflict & ~err_clr);
      handover_err  <= handover_set | (handover_err  & ~err_clr);
    end
  end

endmodule
